// File: rtl/k8088_memctl_if.sv
// ---------------------------------------------------------------------------
// k8088_memctl_if : CPU-side and external-side bus bundle for k8088_memctl.
//
// CPU side
//   cpu_addr   [19:0]  CPU byte address (combinational from the CPU)
//   cpu_dout   [7:0]   write data from the CPU
//   cpu_we             write strobe, held while the CPU is stalled
//   cpu_din    [7:0]   read data returned to the CPU
//   cpu_chipen         CPU clock enable, 1 = access completes this cycle
// External side
//   ext_req            request, held until ext_ack
//   ext_we             1 = external write
//   ext_addr   [19:0]  external address
//   ext_wdata  [7:0]   external write data
//   ext_rdata  [7:0]   external read data, valid in the ack cycle
//   ext_ack            one-cycle completion pulse
//
// Modports: slave  = the memory controller (responder to the CPU, initiator
//                    towards the external port)
//           master = the CPU plus external slave model driving the other end
// ---------------------------------------------------------------------------
interface k8088_memctl_if;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic        cpu_chipen;
    logic        ext_req;
    logic        ext_we;
    logic [19:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_we,
        output cpu_din, cpu_chipen,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_we,
        input  cpu_din, cpu_chipen,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack
    );
endinterface

// File: rtl/k8088_memctl.sv
// ---------------------------------------------------------------------------
// k8088_memctl : memory responder for the k8088 CPU bus.
//
// Serves byte reads/writes. Addresses below 2^FAST_AW hit an on-chip RAM
// with one cycle of read latency; everything else goes to a slow external
// port over a req/ack handshake. A one-entry address/data latch returns
// repeated reads of the last touched address with zero wait states.
//
// Ports
//   clock   system clock
//   reset   synchronous, active-high reset
//   bus     k8088_memctl_if.slave (CPU side and external side, see _if file)
//
// Optional feature macro: K8088_MEM_WP_EN
//   When defined, writes at or above ROM_BASE are silently dropped (they
//   complete at once, touch neither RAM nor the external port, and drop a
//   latch entry for that exact address).
// ---------------------------------------------------------------------------
module k8088_memctl #(
    parameter int          FAST_AW  = 14,
    parameter logic [19:0] ROM_BASE = 20'hF0000
) (
    input  logic            clock,
    input  logic            reset,
    k8088_memctl_if.slave   bus
);

    typedef enum logic [1:0] {
        READY    = 2'd0,
        FILL     = 2'd1,
        EXT_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        lat_valid_q, lat_valid_d;
    logic [19:0] lat_addr_q, lat_addr_d;
    logic [7:0]  lat_data_q, lat_data_d;
    logic [19:0] rd_addr_q, rd_addr_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [19:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;

    logic [7:0]  ram_mem [0:(1 << FAST_AW) - 1];
    logic [7:0]  ram_q;
    logic        ram_we_s;

    logic        fast_s;
    logic        hit_s;
    logic        wp_hit_s;
    logic        chipen_s;
    logic [7:0]  din_s;

    assign fast_s = ((bus.cpu_addr >> FAST_AW) == 20'd0);
    assign hit_s  = lat_valid_q && (lat_addr_q == bus.cpu_addr);

`ifdef K8088_MEM_WP_EN
    assign wp_hit_s = bus.cpu_we && (bus.cpu_addr >= ROM_BASE);
`else
    // Protection disabled: such writes fall through to the external port.
    logic unused_rom_base_s;
    assign unused_rom_base_s = ^ROM_BASE;
    assign wp_hit_s          = 1'b0;
`endif

    // On-chip RAM: synchronous write, registered read of the current CPU
    // address. The CPU holds its address while stalled, so ram_q in the FILL
    // cycle is the byte requested in the preceding READY cycle.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_mem[bus.cpu_addr[FAST_AW-1:0]] <= bus.cpu_dout;
        end
        ram_q <= ram_mem[bus.cpu_addr[FAST_AW-1:0]];
    end

    // Next-state, latch update, external request and CPU response decode.
    always_comb begin
        state_d     = state_q;
        lat_valid_d = lat_valid_q;
        lat_addr_d  = lat_addr_q;
        lat_data_d  = lat_data_q;
        rd_addr_d   = rd_addr_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ram_we_s    = 1'b0;
        chipen_s    = 1'b0;
        din_s       = 8'h00;

        case (state_q)
            READY: begin
                if (wp_hit_s) begin
                    // Protected write: complete immediately, drop stale copy.
                    chipen_s = 1'b1;
                    if (lat_addr_q == bus.cpu_addr) begin
                        lat_valid_d = 1'b0;
                    end else begin
                        lat_valid_d = lat_valid_q;
                    end
                end else if (bus.cpu_we && fast_s) begin
                    // Fast write with write-through into the latch.
                    ram_we_s    = 1'b1;
                    chipen_s    = 1'b1;
                    lat_addr_d  = bus.cpu_addr;
                    lat_data_d  = bus.cpu_dout;
                    lat_valid_d = 1'b1;
                end else if (!bus.cpu_we && hit_s) begin
                    chipen_s = 1'b1;
                    din_s    = lat_data_q;
                end else if (!bus.cpu_we && fast_s) begin
                    rd_addr_d = bus.cpu_addr;
                    state_d   = FILL;
                end else begin
                    ext_req_d   = 1'b1;
                    ext_we_d    = bus.cpu_we;
                    ext_addr_d  = bus.cpu_addr;
                    ext_wdata_d = bus.cpu_dout;
                    state_d     = EXT_WAIT;
                end
            end
            FILL: begin
                chipen_s    = 1'b1;
                din_s       = ram_q;
                lat_addr_d  = rd_addr_q;
                lat_data_d  = ram_q;
                lat_valid_d = 1'b1;
                state_d     = READY;
            end
            EXT_WAIT: begin
                if (bus.ext_ack) begin
                    chipen_s    = 1'b1;
                    lat_addr_d  = ext_addr_q;
                    lat_valid_d = 1'b1;
                    ext_req_d   = 1'b0;
                    state_d     = READY;
                    if (ext_we_q) begin
                        lat_data_d = ext_wdata_q;
                    end else begin
                        din_s      = bus.ext_rdata;
                        lat_data_d = bus.ext_rdata;
                    end
                end else begin
                    chipen_s = 1'b0;
                end
            end
            default: begin
                state_d   = READY;
                ext_req_d = 1'b0;
            end
        endcase
    end

    // State, latch and external-request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= READY;
            lat_valid_q <= 1'b0;
            lat_addr_q  <= 20'h00000;
            lat_data_q  <= 8'h00;
            rd_addr_q   <= 20'h00000;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 20'h00000;
            ext_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            lat_valid_q <= lat_valid_d;
            lat_addr_q  <= lat_addr_d;
            lat_data_q  <= lat_data_d;
            rd_addr_q   <= rd_addr_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
        end
    end

    // CPU response is combinational so hits and ack cycles complete in-cycle;
    // it is forced quiet while reset is held.
    assign bus.cpu_chipen = reset ? 1'b0 : chipen_s;
    assign bus.cpu_din    = reset ? 8'h00 : din_s;

    assign bus.ext_req    = ext_req_q;
    assign bus.ext_we     = ext_we_q;
    assign bus.ext_addr   = ext_addr_q;
    assign bus.ext_wdata  = ext_wdata_q;

endmodule

// File: tb/tb_k8088_memctl.sv
// ---------------------------------------------------------------------------
// tb_k8088_memctl : directed bench for k8088_memctl.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked on the falling edge, registered outputs 1 unit after the rising edge.
// Define K8088_MEM_WP_EN for both bench and RTL to exercise write protection.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_k8088_memctl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    k8088_memctl_if bus ();

    k8088_memctl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // 25 MHz clock.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Single comparison point: counts, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Directed stimulus.
    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.cpu_addr  = 20'h00000;
        bus.cpu_dout  = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.ext_rdata = 8'h00;
        bus.ext_ack   = 1'b0;

        // Reset state.
        tick();
        tick();
        neg();
        chk("rst_chipen", {31'd0, bus.cpu_chipen}, 32'd0);
        chk("rst_din", {24'd0, bus.cpu_din}, 32'd0);
        chk("rst_req", {31'd0, bus.ext_req}, 32'd0);
        chk("rst_addr", {12'd0, bus.ext_addr}, 32'd0);
        chk("rst_we", {31'd0, bus.ext_we}, 32'd0);

        // External read of 0xFFFF0, ack after 3 stall cycles with 0xEA.
        tick();
        rst          = 1'b0;
        bus.cpu_addr = 20'hFFFF0;
        neg();
        chk("ext_rd_stall0", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        chk("ext_rd_req", {31'd0, bus.ext_req}, 32'd1);
        chk("ext_rd_addr", {12'd0, bus.ext_addr}, 32'hFFFF0);
        chk("ext_rd_we", {31'd0, bus.ext_we}, 32'd0);
        neg();
        chk("ext_rd_stall1", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        neg();
        chk("ext_rd_stall2", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'hEA;
        neg();
        chk("ext_rd_done", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("ext_rd_data", {24'd0, bus.cpu_din}, 32'hEA);
        tick();
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = 8'h00;
        chk("ext_rd_req_drop", {31'd0, bus.ext_req}, 32'd0);
        neg();
        chk("ext_rd_lat_hit", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("ext_rd_lat_data", {24'd0, bus.cpu_din}, 32'hEA);

        // Fast write 0x5A to 0x00100, then latch hit.
        tick();
        bus.cpu_addr = 20'h00100;
        bus.cpu_we   = 1'b1;
        bus.cpu_dout = 8'h5A;
        neg();
        chk("wr_fast_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        tick();
        bus.cpu_we = 1'b0;
        chk("wr_fast_noreq", {31'd0, bus.ext_req}, 32'd0);
        neg();
        chk("hit_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("hit_data", {24'd0, bus.cpu_din}, 32'h5A);

        // Preload 0x33 at 0x00101, move latch away, then read with FILL.
        tick();
        bus.cpu_addr = 20'h00101;
        bus.cpu_we   = 1'b1;
        bus.cpu_dout = 8'h33;
        tick();
        bus.cpu_addr = 20'h00102;
        bus.cpu_dout = 8'h77;
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 20'h00101;
        neg();
        chk("fill_stall", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        neg();
        chk("fill_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("fill_data", {24'd0, bus.cpu_din}, 32'h33);

        // Boundary: 0x03FFF is fast, 0x04000 is external.
        tick();
        bus.cpu_addr = 20'h03FFF;
        bus.cpu_we   = 1'b1;
        bus.cpu_dout = 8'hC3;
        tick();
        bus.cpu_addr = 20'h00000;
        bus.cpu_dout = 8'h00;
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 20'h03FFF;
        neg();
        chk("top_fast_stall", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        chk("top_fast_noreq", {31'd0, bus.ext_req}, 32'd0);
        neg();
        chk("top_fast_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("top_fast_data", {24'd0, bus.cpu_din}, 32'hC3);
        tick();
        bus.cpu_addr = 20'h04000;
        neg();
        chk("first_ext_stall", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        chk("first_ext_req", {31'd0, bus.ext_req}, 32'd1);
        chk("first_ext_addr", {12'd0, bus.ext_addr}, 32'h04000);
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'h12;
        neg();
        chk("min_ext_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        chk("min_ext_data", {24'd0, bus.cpu_din}, 32'h12);
        tick();
        bus.ext_ack   = 1'b0;
        chk("min_ext_req_drop", {31'd0, bus.ext_req}, 32'd0);

        // Reset while a request to 0x20000 is outstanding.
        bus.cpu_addr = 20'h20000;
        tick();
        chk("abort_req_up", {31'd0, bus.ext_req}, 32'd1);
        rst = 1'b1;
        neg();
        chk("abort_chipen", {31'd0, bus.cpu_chipen}, 32'd0);
        chk("abort_din", {24'd0, bus.cpu_din}, 32'd0);
        tick();
        chk("abort_req_drop", {31'd0, bus.ext_req}, 32'd0);
        // Latch cleared: 0x04000 (last latched) must miss; stray ack ignored.
        rst           = 1'b0;
        bus.cpu_addr  = 20'h04000;
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'h99;
        neg();
        chk("late_ack_ignored", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        bus.ext_ack   = 1'b0;
        chk("relatch_req", {31'd0, bus.ext_req}, 32'd1);
        chk("relatch_addr", {12'd0, bus.ext_addr}, 32'h04000);
        neg();
        chk("relatch_stall", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'h21;
        neg();
        chk("relatch_data", {24'd0, bus.cpu_din}, 32'h21);
        tick();
        bus.ext_ack = 1'b0;

        // Write 0x11 to 0xF0010 (protected region when the feature is built).
        bus.cpu_addr = 20'hF0010;
        bus.cpu_we   = 1'b1;
        bus.cpu_dout = 8'h11;
        neg();
`ifdef K8088_MEM_WP_EN
        chk("wp_chipen", {31'd0, bus.cpu_chipen}, 32'd1);
        tick();
        chk("wp_noreq", {31'd0, bus.ext_req}, 32'd0);
        bus.cpu_we = 1'b0;
`else
        chk("rom_wr_stall", {31'd0, bus.cpu_chipen}, 32'd0);
        tick();
        chk("rom_wr_req", {31'd0, bus.ext_req}, 32'd1);
        chk("rom_wr_we", {31'd0, bus.ext_we}, 32'd1);
        chk("rom_wr_wdata", {24'd0, bus.ext_wdata}, 32'h11);
        bus.ext_ack = 1'b1;
        neg();
        chk("rom_wr_done", {31'd0, bus.cpu_chipen}, 32'd1);
        tick();
        bus.ext_ack = 1'b0;
        bus.cpu_we  = 1'b0;
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
